// File: rtl/usb_serial_tx_arbiter_if.sv
// Byte-stream bundle between the per-requester send FIFOs, the round-robin
// arbiter and the single IN endpoint send buffer.
interface usb_serial_tx_arbiter_if #(
    parameter int NCH = 4,
    parameter int AW  = 11
);
    logic [NCH*8-1:0]  in_data;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [NCH*AW-1:0] in_avail;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  in_data, in_valid, in_avail, out_ready,
        output in_ready, out_data, out_valid
    );

    modport slave (
        output in_data, in_valid, in_avail, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/usb_serial_tx_arbiter.sv
// Round-robin merge of NCH requester byte streams onto one IN endpoint stream;
// every grant is framed by a {channel, length-1} header byte.
module usb_serial_tx_arbiter #(
    parameter int NCH      = 4,
    parameter int MAXBURST = 32,
    parameter int AW       = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    usb_serial_tx_arbiter_if.master bus,
    output logic                    busy,
    output logic [2:0]              cur_ch
);
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t        state_q;
    logic [2:0]    rrLast_q;
    logic [2:0]    curCh_q;
    logic [5:0]    len_q;
    logic [5:0]    rem_q;
    logic [7:0]    outData_q;
    logic          outValid_q;
    logic          busy_q;

    logic [AW-1:0] availAll [8];
    logic [7:0]    dataAll  [8];
    logic [7:0]    validAll;
    logic [NCH-1:0] inReady_d;
    logic          slotFree;
    logic          winFound_d;
    logic [2:0]    winCh_d;
    logic [5:0]    winLen_d;
    logic          accept_d;

    function automatic logic [2:0] chanAfter(input logic [2:0] base, input int step);
        return 3'((int'(base) + step) % NCH);
    endfunction

    // Widen the per-requester vectors to the full 3-bit channel space so the
    // channel number can index them directly; absent channels read as empty.
    for (genvar g = 0; g < 8; g++) begin : g_unpack
        if (g < NCH) begin : g_used
            assign availAll[g] = bus.in_avail[AW*g +: AW];
            assign dataAll[g]  = bus.in_data[8*g +: 8];
            assign validAll[g] = bus.in_valid[g];
        end else begin : g_unused
            assign availAll[g] = '0;
            assign dataAll[g]  = '0;
            assign validAll[g] = 1'b0;
        end
    end

    assign slotFree = !outValid_q || bus.out_ready;

    // Scanning from the farthest candidate back lets the nearest one after rrLast_q win.
    always_comb begin
        winFound_d = 1'b0;
        winCh_d    = '0;
        for (int i = NCH; i >= 1; i--) begin
            if (availAll[chanAfter(rrLast_q, i)] != '0) begin
                winFound_d = 1'b1;
                winCh_d    = chanAfter(rrLast_q, i);
            end
        end
    end

    always_comb begin
        if (availAll[winCh_d] > AW'(MAXBURST)) begin
            winLen_d = 6'(MAXBURST);
        end else begin
            winLen_d = 6'(availAll[winCh_d]);
        end
    end

    always_comb begin
        inReady_d = '0;
        for (int c = 0; c < NCH; c++) begin
            inReady_d[c] = (state_q == DATA) && (rem_q != '0) && slotFree && (curCh_q == 3'(c));
        end
    end

    assign accept_d = (state_q == DATA) && (rem_q != '0) && slotFree && validAll[curCh_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rrLast_q   <= 3'(NCH - 1);
            curCh_q    <= '0;
            len_q      <= '0;
            rem_q      <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (outValid_q && bus.out_ready) begin
                outValid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (winFound_d) begin
                        curCh_q <= winCh_d;
                        len_q   <= winLen_d;
                        busy_q  <= 1'b1;
                        state_q <= HDR;
                    end
                end
                HDR: begin
                    if (slotFree) begin
                        outData_q  <= {curCh_q, 5'(len_q - 6'd1)};
                        outValid_q <= 1'b1;
                        rem_q      <= len_q;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (accept_d) begin
                        outData_q  <= dataAll[curCh_q];
                        outValid_q <= 1'b1;
                        rem_q      <= rem_q - 6'd1;
                        if (rem_q == 6'd1) begin
                            rrLast_q <= curCh_q;
                            busy_q   <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = inReady_d;
    assign bus.out_data  = outData_q;
    assign bus.out_valid = outValid_q;
    assign busy          = busy_q;
    assign cur_ch        = curCh_q;
endmodule

// File: doc/usb_serial_tx_arbiter.md
Name: usb_serial_tx_arbiter

Overview:
- Shares one device-to-host CDC byte stream (one IN endpoint data path) among NCH requester byte streams using round-robin arbitration.
- Each grant emits a one-byte header {channel, burst length-1}, followed by exactly that many payload bytes from the granted requester, so the host can demultiplex.
- Sits between per-requester send FIFOs (which report their fill level) and a single send buffer / IN endpoint.

Parameters:
- NCH, 4, number of requesters; legal range 2..8.
- MAXBURST, 32, maximum payload bytes per grant; legal range 1..32.
- AW, 11, width of each requester's available-byte count.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- in_data  input  NCH*8  requester bytes; requester i occupies bits [8i+7:8i]
- in_valid  input  NCH  per-requester byte valid
- in_ready  output  NCH  per-requester byte ready; transfer when valid&ready
- in_avail  input  NCH*AW  per-requester count of bytes it guarantees it can deliver; requester i occupies bits [AW*i+AW-1:AW*i]
- out_data  output  8  merged stream byte (header or payload)
- out_valid  output  1  merged stream valid
- out_ready  input  1  downstream ready
- busy  output  1  1 while in HDR or DATA state
- cur_ch  output  3  currently granted channel; holds the last grant when idle

Behaviour:
- Reset values (asynchronous, all outputs): out_valid=0, out_data=0, in_ready=0, busy=0, cur_ch=0, state=IDLE, rr_last=NCH-1, rem=0.
- Output register:
  - out_data and out_valid are registered.
  - slot_free = !out_valid | out_ready.
  - On a cycle where out_valid&out_ready and nothing new is loaded, out_valid goes to 0.
- State IDLE:
  - Scan channels rr_last+1, rr_last+2, … modulo NCH.
  - Winner w is the first channel with in_avail≠0.
  - If a winner exists: latch cur_ch=w and len=min(in_avail[w],MAXBURST), then go to HDR.
  - If no winner: stay in IDLE.
- State HDR:
  - When slot_free: load out_data={w[2:0],(len-1)[4:0]}, set out_valid=1, rem=len, go to DATA.
  - Otherwise hold.
- State DATA:
  - in_ready[cur_ch] = slot_free & (rem≠0); all other in_ready bits are 0.
  - On in_valid[cur_ch]&in_ready[cur_ch]: load out_data=byte, set out_valid=1, rem=rem-1.
  - When the last byte is accepted (rem 1→0): set rr_last=cur_ch and go to IDLE.
- Stalls:
  - A requester dropping valid mid-burst stalls DATA indefinitely; there is no timeout.
  - The committed length is never shortened.
  - Requester contract: in_avail counts only bytes it will present.
- Latency:
  - Starting in IDLE with an empty output and in_avail changing at cycle 0, the header is on out_valid from cycle 2.
  - With continuous valid and ready, payload streams at 1 byte/cycle.
  - There is exactly one IDLE cycle between bursts.
  - Per-burst overhead is header + 1 idle cycle.
- Boundaries:
  - in_avail > MAXBURST is clipped to MAXBURST, and the header encodes MAXBURST-1.
  - in_avail changes after the IDLE sample are ignored until the next IDLE.
  - Header channel field uses bits [7:5]; for NCH<8 the unused codes never appear.
  - MAXBURST=32 encodes len-1=31 in 5 bits. No other arithmetic overflow is possible.
- Fairness: each channel with avail≠0 is granted within NCH-1 other bursts.
- Reset mid-burst: the output byte is discarded and the partial burst is abandoned. Downstream must tolerate a truncated frame on reset.

Test Plan:
- Single channel: ch2 avail=3, bytes 0x11,0x22,0x33, out_ready=1 → out stream 0x42,0x11,0x22,0x33; busy low afterwards; cur_ch=2.
- Round robin: all 4 channels avail=1 at once after reset → header order 0x00,0x20,0x40,0x60, each followed by its byte; a repeat with ch0 and ch1 active only → next grant ch0, then ch1.
- Clipping: ch1 avail=100, MAXBURST=32 → header 0x3F, then 32 bytes; IDLE re-grants ch1 (the only requester) with len=min(68,32) → header 0x3F.
- Backpressure: toggle out_ready 1/0 every cycle during a 5-byte burst on ch3 → no byte lost or duplicated; out_data stable while out_valid&!out_ready; in_ready[3] low whenever the slot is not free.
- Requester stall: ch0 avail=4, in_valid low for 10 cycles after byte 2 → arbiter holds DATA with rem=2; other channels' in_ready stay 0; burst completes when valid returns.
- Reset mid-burst: assert rst during byte 3 of 8 → out_valid=0 and in_ready=0 immediately; after release, first grant goes to ch0 (rr_last=NCH-1).
